bus_mux_reg: RTL and testbench

//  Registered, parametrised successor to the datapath bus multiplexer. Selects DIN, ALU result or one of

---
 rtl/bus_mux_reg_pkg.sv | 9 +
 rtl/bus_mux_reg_conflict.sv | 35 +++
 rtl/bus_mux_reg.sv | 76 +++++++
 tb/tb_bus_mux_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bus_mux_reg_pkg.sv
// bus_mux_reg_pkg: source codes shared by the bus multiplexer and its bench.
package bus_mux_reg_pkg;
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DIN  = 2'd1,
        SRC_ALU  = 2'd2,
        SRC_REG  = 2'd3
    } bus_src_e;
endpackage

// File: rtl/bus_mux_reg_conflict.sv
// bus_conflict_mon: sticky flag and saturating count of cycles with more than one bus source enabled.
module bus_conflict_mon #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_en,
    input  logic          gout,
    input  logic          rout_en,
    input  logic          clr_conflict,
    output logic          conflict,
    output logic [CW-1:0] conflict_cnt
);
    logic          hit;
    logic          conflict_d, conflict_q;
    logic [CW-1:0] cnt_d, cnt_q;
    always_comb begin
        hit        = (din_en & gout) | (din_en & rout_en) | (gout & rout_en);
        conflict_d = hit ? 1'b1 : clr_conflict ? 1'b0 : conflict_q;
        // a conflict in the clearing cycle restarts the count at one
        cnt_d      = hit ? (clr_conflict ? CW'(1) : (&cnt_q ? cnt_q : cnt_q + CW'(1)))
                         : (clr_conflict ? '0 : cnt_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered priority bus multiplexer (din > alu > register) with hold and conflict tracking.
module bus_mux_reg
    import bus_mux_reg_pkg::*;
#(
    parameter int             W          = 16,
    parameter int             NREG       = 8,
    parameter int             CW         = 8,
    parameter logic [W-1:0]   IDLE_VALUE = '0,
    localparam int            RW         = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_en,
    input  logic [W-1:0]      aluout,
    input  logic              gout,
    input  logic [NREG*W-1:0] r_flat,
    input  logic [RW-1:0]     rout,
    input  logic              rout_en,
    input  logic              bus_hold,
    input  logic              clr_conflict,
    output logic [W-1:0]      buswires,
    output logic              bus_valid,
    output logic [1:0]        bus_src,
    output logic [RW-1:0]     bus_reg,
    output logic              conflict,
    output logic [CW-1:0]     conflict_cnt
);
    logic [W-1:0]  reg_val, sel_bus;
    logic          reg_ok;
    bus_src_e      sel_src;
    logic [W-1:0]  bus_d, bus_q;
    logic          valid_d, valid_q;
    bus_src_e      src_d, src_q;
    logic [RW-1:0] reg_d, reg_q;
    always_comb begin
        reg_val = IDLE_VALUE;
        for (int i = 0; i < NREG; i++)
            if (rout == RW'(i)) reg_val = r_flat[i*W +: W];
        // indices past NREG (non power-of-two NREG) select nothing
        reg_ok  = int'(rout) < NREG;
        sel_src = din_en ? SRC_DIN : gout ? SRC_ALU : (rout_en && reg_ok) ? SRC_REG : SRC_NONE;
        sel_bus = din_en ? din : gout ? aluout : (sel_src == SRC_REG) ? reg_val : IDLE_VALUE;
        bus_d   = bus_hold ? bus_q : sel_bus;
        valid_d = bus_hold ? valid_q : (sel_src != SRC_NONE);
        src_d   = bus_hold ? src_q : sel_src;
        reg_d   = bus_hold ? reg_q : (sel_src == SRC_REG) ? rout : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= IDLE_VALUE;
            valid_q <= 1'b0;
            src_q   <= SRC_NONE;
            reg_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            reg_q   <= reg_d;
        end
    end
    bus_conflict_mon #(.CW(CW)) u_mon (
        .clk          (clk),
        .rst          (rst),
        .din_en       (din_en),
        .gout         (gout),
        .rout_en      (rout_en),
        .clr_conflict (clr_conflict),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );
    assign buswires  = bus_q;
    assign bus_valid = valid_q;
    assign bus_src   = src_q;
    assign bus_reg   = reg_q;
endmodule

// File: tb/tb_bus_mux_reg.sv
// tb_bus_mux_reg: directed and random checks of bus_mux_reg (NREG=8 and NREG=6) against a cycle model.
module tb_bus_mux_reg;
    logic         clk = 0, rst = 1;
    logic         din_en = 0, gout = 0, rout_en = 0, bus_hold = 0, clr = 0;
    logic [15:0]  din = 16'hAAAA, aluout = 16'hBBBB;
    logic [127:0] r_flat;
    logic [2:0]   rout = 0;
    logic [15:0]  bw8, bw6;
    logic         v8, v6, cf8, cf6;
    logic [1:0]   s8, s6;
    logic [2:0]   r8, r6;
    logic [7:0]   c8, c6;
    int           n_chk = 0, n_pass = 0;
    logic [15:0]  m_bus[2];
    logic         m_valid[2];
    logic [1:0]   m_src[2];
    logic [2:0]   m_reg[2];
    logic         m_conf;
    int           m_cnt;

    bus_mux_reg #(.W(16), .NREG(8), .CW(8), .IDLE_VALUE(16'h0)) u8 (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .aluout(aluout), .gout(gout),
        .r_flat(r_flat), .rout(rout), .rout_en(rout_en), .bus_hold(bus_hold),
        .clr_conflict(clr), .buswires(bw8), .bus_valid(v8), .bus_src(s8), .bus_reg(r8),
        .conflict(cf8), .conflict_cnt(c8));
    bus_mux_reg #(.W(16), .NREG(6), .CW(8), .IDLE_VALUE(16'h0)) u6 (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .aluout(aluout), .gout(gout),
        .r_flat(r_flat[95:0]), .rout(rout), .rout_en(rout_en), .bus_hold(bus_hold),
        .clr_conflict(clr), .buswires(bw6), .bus_valid(v6), .bus_src(s6), .bus_reg(r6),
        .conflict(cf6), .conflict_cnt(c6));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic model();
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_bus[k] = 0; m_valid[k] = 0; m_src[k] = 0; m_reg[k] = 0;
            end
            m_conf = 0; m_cnt = 0;
        end else begin
            int n;
            n = int'(din_en) + int'(gout) + int'(rout_en);
            if (n >= 2) begin
                m_conf = 1;
                m_cnt  = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_conf = 0; m_cnt = 0;
            end
            if (!bus_hold)
                for (int k = 0; k < 2; k++) begin
                    int nreg;
                    nreg = (k == 0) ? 8 : 6;
                    m_reg[k] = 0; m_valid[k] = 1;
                    if (din_en) begin m_bus[k] = din; m_src[k] = 1; end
                    else if (gout) begin m_bus[k] = aluout; m_src[k] = 2; end
                    else if (rout_en && int'(rout) < nreg) begin
                        m_bus[k] = r_flat[int'(rout)*16 +: 16]; m_src[k] = 3; m_reg[k] = rout;
                    end else begin
                        m_bus[k] = 0; m_src[k] = 0; m_valid[k] = 0;
                    end
                end
        end
    endtask

    task automatic check_all();
        chk("bus8", bw8, m_bus[0]);   chk("bus6", bw6, m_bus[1]);
        chk("valid8", 16'(v8), 16'(m_valid[0])); chk("valid6", 16'(v6), 16'(m_valid[1]));
        chk("src8", 16'(s8), 16'(m_src[0]));     chk("src6", 16'(s6), 16'(m_src[1]));
        chk("reg8", 16'(r8), 16'(m_reg[0]));     chk("reg6", 16'(r6), 16'(m_reg[1]));
        chk("conf8", 16'(cf8), 16'(m_conf));     chk("conf6", 16'(cf6), 16'(m_conf));
        chk("cnt8", 16'(c8), 16'(m_cnt));        chk("cnt6", 16'(c6), 16'(m_cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        model();
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) r_flat[i*16 +: 16] = {4{4'(i)}};
        // reset with active inputs
        din_en = 1; gout = 1; rout_en = 1; bus_hold = 1;
        cyc(); cyc();
        chk("rst_bus", bw8, 16'h0000); chk("rst_cnt", 16'(c8), 16'h0);
        rst = 0; bus_hold = 0;
        // priority
        rout = 0;
        cyc();
        chk("pri_din", bw8, 16'hAAAA); chk("pri_src", 16'(s8), 16'h1);
        chk("pri_cnt", 16'(c8), 16'h1);
        din_en = 0;
        cyc();
        chk("pri_alu", bw8, 16'hBBBB); chk("pri_cnt2", 16'(c8), 16'h2);
        gout = 0;
        // register sweep
        for (int i = 0; i < 8; i++) begin
            rout = 3'(i);
            cyc();
            chk("sweep", bw8, {4{4'(i)}}); chk("sweep_reg", 16'(r8), 16'(i));
        end
        chk("sweep_cnt", 16'(c8), 16'h2);
        // hold
        rout = 5;
        cyc();
        bus_hold = 1; rout = 2; r_flat[5*16 +: 16] = 16'h1234;
        cyc(); cyc();
        chk("hold", bw8, 16'h5555);
        bus_hold = 0;
        cyc();
        chk("release", bw8, 16'h2222);
        // idle and range
        rout_en = 0;
        cyc();
        chk("idle", bw8, 16'h0000); chk("idle_v", 16'(v8), 16'h0);
        rout_en = 1; rout = 7;
        cyc();
        chk("rng6", bw6, 16'h0000); chk("rng6_src", 16'(s6), 16'h0);
        chk("rng8", bw8, 16'h7777);
        // saturation and clear
        din_en = 1; gout = 1; rout_en = 0;
        for (int i = 0; i < 300; i++) cyc();
        chk("sat", 16'(c8), 16'h00FF);
        clr = 1;
        cyc();
        chk("clr_conf", 16'(c8), 16'h1);
        din_en = 0; gout = 0;
        cyc();
        chk("clr_alone", 16'(c8), 16'h0); chk("clr_flag", 16'(cf8), 16'h0);
        clr = 0; din_en = 1;
        cyc();
        bus_hold = 1; rst = 1;
        cyc();
        chk("rst_hold", bw8, 16'h0000);
        rst = 0; bus_hold = 0; din_en = 0;
        // random
        for (int i = 0; i < 400; i++) begin
            din_en   = $urandom_range(0, 2) == 0;
            gout     = $urandom_range(0, 2) == 0;
            rout_en  = $urandom_range(0, 1) == 1;
            rout     = 3'($urandom_range(0, 7));
            bus_hold = $urandom_range(0, 3) == 0;
            clr      = $urandom_range(0, 7) == 0;
            rst      = $urandom_range(0, 31) == 0;
            din      = 16'($urandom);
            aluout   = 16'($urandom);
            r_flat[$urandom_range(0, 7)*16 +: 16] = 16'($urandom);
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
